// File: rtl/activation_unit.sv
// activation_unit: ReLU or PLAN-sigmoid activation of an accumulator sum, one registered cycle of latency.
module activation_unit #(
    parameter int    DATA_W   = 16,
    parameter int    W_INT    = 4,
    parameter int    SIG_W    = 10,
    parameter string ACT_TYPE = "sigmoid_LU"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   sum,
    output logic [DATA_W-1:0]     out,
    output logic                  out_valid
);
    localparam int OF   = DATA_W - W_INT;
    localparam int XF   = SIG_W - W_INT;
    localparam int SH   = OF - XF;
    localparam int HALF = 2 ** (SIG_W - 1);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << OF;

    function automatic logic [DATA_W-1:0] plan(input int a);
        int af, y;
        af = a << SH;
        if (a < (1 << XF)) y = (af >> 2) + (1 << OF) / 2;
        else if (a < (19 << XF) / 8) y = (af >> 3) + 5 * (1 << OF) / 8;
        else if (a < (5 << XF)) y = (af >> 5) + 27 * (1 << OF) / 32;
        else y = 1 << OF;
        return DATA_W'(y);
    endfunction

    function automatic logic [DATA_W-1:0] sig(input int x);
        return (x < 0) ? ONE - plan(-x) : plan(x);
    endfunction

    logic [DATA_W-1:0] act;
    logic              unused_sum;
    assign unused_sum = ^sum;

    if (ACT_TYPE == "relu") begin : g_relu
        always_comb act = sum[2*DATA_W-1] ? '0 :
                          (|sum[2*DATA_W-2 -: W_INT]) ? {1'b0, {DATA_W-1{1'b1}}} :
                          sum[2*DATA_W-1-W_INT -: DATA_W];
    end else begin : g_sig
        logic [SIG_W-1:0] x;
        assign x = sum[2*DATA_W-1-W_INT -: SIG_W];
        if (ACT_TYPE == "sigmoid_nor") begin : g_nor
            logic [DATA_W-1:0] lut [2*HALF];
            logic [SIG_W-1:0]  idx;
            for (genvar i = 0; i < 2*HALF; i++) begin : g_t
                assign lut[i] = sig(i - HALF);
            end
            assign idx = {~x[SIG_W-1], x[SIG_W-2:0]};
            always_comb act = lut[idx];
        end else begin : g_lu
            // magnitude 2^(SIG_W-1) only arises from the most negative x; its entry is 1.0 anyway
            logic [DATA_W-1:0] lut [HALF];
            logic [SIG_W-1:0]  a;
            logic [SIG_W-2:0]  idx;
            for (genvar i = 0; i < HALF; i++) begin : g_t
                assign lut[i] = plan(i);
            end
            always_comb begin
                a   = sum[2*DATA_W-1] ? -x : x;
                idx = a[SIG_W-1] ? (SIG_W-1)'(HALF-1) : a[SIG_W-2:0];
                act = sum[2*DATA_W-1] ? ONE - lut[idx] : lut[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= act;
        end
    end
endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed checks of the three activation modes, handshake and async reset.
module tb_activation_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] sum = '0;
    logic [15:0] out_lu, out_nor, out_relu;
    logic        ov_lu, ov_nor, ov_relu;
    int          checks = 0;
    int          failures = 0;

    activation_unit #(.ACT_TYPE("sigmoid_LU")) u_lu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_lu), .out_valid(ov_lu));
    activation_unit #(.ACT_TYPE("sigmoid_nor")) u_nor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_nor), .out_valid(ov_nor));
    activation_unit #(.ACT_TYPE("relu")) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_relu), .out_valid(ov_relu));

    always #5 clk = ~clk;

    function automatic logic [15:0] gold(input int x);
        int a, y;
        a = (x < 0) ? -x : x;
        if (a < 64) y = 2048 + 16 * a;
        else if (a < 152) y = 2560 + 8 * a;
        else if (a < 320) y = 3456 + 2 * a;
        else y = 4096;
        if (x < 0) y = 4096 - y;
        return 16'(y);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        sum = 32'h0100_0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_lu, ov_lu, out_nor, ov_nor, out_relu, ov_relu} !== 51'd0) begin
            failures++;
            $display("FAIL reset_state lu=%h/%b nor=%h/%b relu=%h/%b expected 0000/0",
                     out_lu, ov_lu, out_nor, ov_nor, out_relu, ov_relu);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sigmoid(input string name, input logic [31:0] v [], input logic [15:0] e []);
        for (int k = 0; k < v.size(); k++) begin
            sum = v[k];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_lu !== e[k] || ov_lu !== 1'b1) begin
                failures++;
                $display("FAIL %s_lu sum=%h got=%h/%b expected %h/1", name, v[k], out_lu, ov_lu, e[k]);
            end
            checks++;
            if (out_nor !== e[k] || ov_nor !== 1'b1) begin
                failures++;
                $display("FAIL %s_nor sum=%h got=%h/%b expected %h/1", name, v[k], out_nor, ov_nor, e[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mode_equiv();
        logic [9:0] xs;
        int xi;
        for (int i = 0; i < 1024; i++) begin
            xs = 10'(i);
            xi = (i < 512) ? i : i - 1024;
            sum = {{4{xs[9]}}, xs, 18'h15A5A};
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_lu !== gold(xi) || out_nor !== gold(xi)) begin
                failures++;
                $display("FAIL mode_equiv x=%0d lu=%h nor=%h expected %h", xi, out_lu, out_nor, gold(xi));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_relu();
        logic [31:0] v [4] = '{32'h0100_0000, 32'h8000_0000, 32'h1000_0000, 32'h0000_1FFF};
        logic [15:0] e [4] = '{16'h1000, 16'h0000, 16'h7FFF, 16'h0001};
        for (int k = 0; k < 4; k++) begin
            sum = v[k];
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_relu !== e[k] || ov_relu !== 1'b1) begin
                failures++;
                $display("FAIL relu sum=%h got=%h/%b expected %h/1", v[k], out_relu, ov_relu, e[k]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        iv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] v  [5] = '{32'h0000_0000, 32'h0100_0000, 32'hFF00_0000, 32'hFF00_0000, 32'h0};
        logic        eov [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] eo  [5] = '{16'hxxxx, 16'h0800, 16'h0C00, 16'h0C00, 16'h0400};
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ov_lu !== eov[k] || (k > 0 && out_lu !== eo[k])) begin
                failures++;
                $display("FAIL handshake cycle=%0d got=%h/%b expected %h/%b", k, out_lu, ov_lu, eo[k], eov[k]);
            end
            in_valid = iv[k];
            sum = v[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        sum = 32'h0100_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (ov_lu !== 1'b1 || out_lu !== 16'h0C00) begin
            failures++;
            $display("FAIL pre_reset got=%h/%b expected 0c00/1", out_lu, ov_lu);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_lu, ov_lu, out_nor, ov_nor, out_relu, ov_relu} !== 51'd0) begin
            failures++;
            $display("FAIL async_reset lu=%h/%b nor=%h/%b relu=%h/%b expected 0000/0",
                     out_lu, ov_lu, out_nor, ov_nor, out_relu, ov_relu);
        end
        @(negedge clk);
        rst = 1'b1;
        sum = 32'h0500_0000;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_lu !== 16'h1000 || ov_lu !== 1'b1 || out_relu !== 16'h5000 || ov_relu !== 1'b1) begin
            failures++;
            $display("FAIL restart lu=%h/%b relu=%h/%b expected 1000/1 5000/1", out_lu, ov_lu, out_relu, ov_relu);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] bv [] = '{32'h0000_0000, 32'h0100_0000, 32'hFF00_0000};
        logic [15:0] be [] = '{16'h0800, 16'h0C00, 16'h0400};
        logic [31:0] xv [] = '{32'h0500_0000, 32'hF800_0000, 32'h0780_0000};
        logic [15:0] xe [] = '{16'h1000, 16'h0000, 16'h1000};
        test_reset();
        test_sigmoid("sig_basic", bv, be);
        test_sigmoid("sig_extreme", xv, xe);
        test_mode_equiv();
        test_relu();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
